// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - iterative AES-128 round controller driving one shared external round unit
module aes_round_sequencer #(
  parameter int NUM_ROUNDS = 10,
  parameter int ROUND_LAT  = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   key_idx,
  input  logic [127:0] rk_in,
  output logic [127:0] rnd_state_out,
  output logic [127:0] rnd_key_out,
  output logic         rnd_final,
  input  logic [127:0] rnd_state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic [3:0]   round
);

  localparam int              LW         = (ROUND_LAT > 1) ? $clog2(ROUND_LAT) : 1;
  localparam logic [3:0]      LAST_ROUND = 4'(NUM_ROUNDS);
  localparam logic [LW-1:0]   LAT_LAST   = LW'(ROUND_LAT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  state_t        state_next;
  logic [127:0]  state_reg;
  logic [LW-1:0] lat_cnt;
  logic          capture;

  assign capture = (state == RUN) && (lat_cnt == LAT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (capture && (round == LAST_ROUND)) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_comb begin
    in_ready      = (state == IDLE);
    busy          = (state != IDLE);
    out_valid     = (state == DONE);
    key_idx       = (state == RUN) ? round : 4'd0;
    rnd_final     = (state == RUN) && (round == LAST_ROUND);
    rnd_state_out = state_reg;
    rnd_key_out   = rk_in;
  end

  // flush leaves state_reg and out_data alone; only the sequencing state is cleared
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= '0;
      round     <= 4'd0;
      lat_cnt   <= '0;
      out_data  <= '0;
    end else if (flush) begin
      round   <= 4'd0;
      lat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state_reg <= in_data ^ rk_in;
            round     <= 4'd1;
            lat_cnt   <= '0;
          end
        end
        RUN: begin
          if (capture) begin
            state_reg <= rnd_state_in;
            lat_cnt   <= '0;
            if (round == LAST_ROUND) begin
              out_data <= rnd_state_in;
            end else begin
              round <= round + 4'd1;
            end
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end
        DONE: begin
          if (out_ready) round <= 4'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb/tb_aes_round_sequencer.sv - bench for aes_round_sequencer with behavioural AES round unit and key store
module tb_aes_round_sequencer;

  typedef logic [10:0][127:0] rk_t;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  logic         flush_a, in_valid_a, in_ready_a, rnd_final_a, out_valid_a, out_ready_a, busy_a;
  logic [127:0] in_data_a, rk_in_a, rnd_state_out_a, rnd_key_out_a, rnd_state_in_a, out_data_a;
  logic [3:0]   key_idx_a, round_a;
  logic [127:0] rks_a [16];

  logic         flush_b, in_valid_b, in_ready_b, rnd_final_b, out_valid_b, out_ready_b, busy_b;
  logic [127:0] in_data_b, rk_in_b, rnd_state_out_b, rnd_key_out_b, rnd_state_in_b, out_data_b;
  logic [3:0]   key_idx_b, round_b;
  logic [127:0] rks_b [16];
  logic [127:0] f_b, d1_b, d2_b;

  logic [127:0] last_ct;

  always #5 clk = ~clk;

  aes_round_sequencer #(.NUM_ROUNDS(10), .ROUND_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .flush(flush_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .key_idx(key_idx_a), .rk_in(rk_in_a), .rnd_state_out(rnd_state_out_a),
    .rnd_key_out(rnd_key_out_a), .rnd_final(rnd_final_a), .rnd_state_in(rnd_state_in_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a), .busy(busy_a), .round(round_a)
  );

  aes_round_sequencer #(.NUM_ROUNDS(10), .ROUND_LAT(3)) dut_b (
    .clk(clk), .reset(reset), .flush(flush_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .key_idx(key_idx_b), .rk_in(rk_in_b), .rnd_state_out(rnd_state_out_b),
    .rnd_key_out(rnd_key_out_b), .rnd_final(rnd_final_b), .rnd_state_in(rnd_state_in_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b), .busy(busy_b), .round(round_b)
  );

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse (x^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    logic [7:0] e;
    r = 8'h01;
    p = x;
    e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, p);
      p = gmul(p, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic fin);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r+4*c] = b[r+4*((c+r)%4)];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
        t[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o ^ k;
  endfunction

  function automatic rk_t expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rcon;
    rk_t         rk;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp  = {sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0]), sbox(tmp[31:24])} ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rk;
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] key);
    rk_t          rk;
    logic [127:0] s;
    rk = expand_key(key);
    s  = pt ^ rk[0];
    for (int r = 1; r <= 10; r++) s = aes_round(s, rk[r], r == 10);
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  assign rk_in_a = rks_a[key_idx_a];
  assign rk_in_b = rks_b[key_idx_b];

  always_comb rnd_state_in_a = aes_round(rnd_state_out_a, rnd_key_out_a, rnd_final_a);

  // the ROUND_LAT=3 round unit only presents its result two cycles after the inputs appear
  always_comb f_b = aes_round(rnd_state_out_b, rnd_key_out_b, rnd_final_b);
  always @(posedge clk) begin
    d1_b <= f_b;
    d2_b <= d1_b;
  end
  assign rnd_state_in_b = d2_b;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_keys_a(input logic [127:0] key);
    rk_t rk;
    rk = expand_key(key);
    for (int r = 0; r < 16; r++) rks_a[r] = (r < 11) ? rk[r] : '0;
  endtask

  task automatic run_a(input logic [127:0] pt, input logic [127:0] key, input int delay,
                       input logic chain, input logic [127:0] next_pt);
    logic [127:0] exp_ct;
    exp_ct = aes_encrypt(pt, key);
    load_keys_a(key);
    in_data_a  = pt;
    in_valid_a = 1'b1;
    #1;
    chk("a_accept_ready", 128'(in_ready_a), 128'(1));
    chk("a_accept_idx", 128'(key_idx_a), 128'(0));
    @(negedge clk);
    in_valid_a = 1'b0;
    in_data_a  = rand128();
    for (int k = 1; k <= 10; k++) begin
      chk("a_key_idx", 128'(key_idx_a), 128'(k));
      chk("a_rnd_final", 128'(rnd_final_a), 128'(k == 10));
      chk("a_run_ready", 128'(in_ready_a), 128'(0));
      chk("a_run_valid", 128'(out_valid_a), 128'(0));
      @(negedge clk);
    end
    for (int d = 0; d < delay; d++) begin
      chk("a_bp_valid", 128'(out_valid_a), 128'(1));
      chk("a_bp_data", out_data_a, exp_ct);
      chk("a_bp_ready", 128'(in_ready_a), 128'(0));
      @(negedge clk);
    end
    chk("a_out_valid", 128'(out_valid_a), 128'(1));
    chk("a_out_data", out_data_a, exp_ct);
    out_ready_a = 1'b1;
    if (chain) begin
      in_valid_a = 1'b1;
      in_data_a  = next_pt;
    end
    #1;
    chk("a_done_no_accept", 128'(in_ready_a), 128'(0));
    @(negedge clk);
    out_ready_a = 1'b0;
    chk("a_idle_busy", 128'(busy_a), 128'(0));
    chk("a_idle_round", 128'(round_a), 128'(0));
    chk("a_idle_data_hold", out_data_a, exp_ct);
    last_ct = exp_ct;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] pts  [7];
    logic [127:0] keys [6];
    logic [127:0] pt_f, key_f, pt_g;
    rk_t          rk;

    reset = 1'b0;
    flush_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b0; in_data_a = '0;
    flush_b = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b0; in_data_b = '0;
    for (int r = 0; r < 16; r++) begin
      rks_a[r] = '0;
      rks_b[r] = '0;
    end
    repeat (2) @(negedge clk);

    chk("rst_busy", 128'(busy_a), 128'(0));
    chk("rst_out_valid", 128'(out_valid_a), 128'(0));
    chk("rst_out_data", out_data_a, 128'(0));
    chk("rst_key_idx", 128'(key_idx_a), 128'(0));
    chk("rst_rnd_final", 128'(rnd_final_a), 128'(0));
    chk("rst_in_ready", 128'(in_ready_a), 128'(1));
    chk("rst_round", 128'(round_a), 128'(0));
    chk("rst_in_ready_b", 128'(in_ready_b), 128'(1));
    reset = 1'b1;
    @(negedge clk);

    // ROUND_LAT=3 instance: each key index held for three cycles, result 31 cycles after accept
    rk = expand_key(FIPS_KEY);
    for (int r = 0; r < 16; r++) rks_b[r] = (r < 11) ? rk[r] : '0;
    in_data_b  = FIPS_PT;
    in_valid_b = 1'b1;
    #1;
    chk("b_accept_ready", 128'(in_ready_b), 128'(1));
    @(negedge clk);
    in_valid_b = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      chk("b_key_idx", 128'(key_idx_b), 128'((k - 1) / 3 + 1));
      chk("b_rnd_final", 128'(rnd_final_b), 128'(((k - 1) / 3 + 1) == 10));
      chk("b_run_valid", 128'(out_valid_b), 128'(0));
      @(negedge clk);
    end
    chk("b_out_valid", 128'(out_valid_b), 128'(1));
    chk("b_out_data", out_data_b, FIPS_CT);
    out_ready_b = 1'b1;
    @(negedge clk);
    out_ready_b = 1'b0;
    chk("b_idle_busy", 128'(busy_b), 128'(0));

    // FIPS vector with 5 cycles of backpressure, then a chain of random blocks
    for (int i = 0; i < 7; i++) pts[i] = rand128();
    for (int i = 0; i < 6; i++) keys[i] = rand128();
    run_a(FIPS_PT, FIPS_KEY, 5, 1'b1, pts[0]);
    chk("a_fips_vector", out_data_a, FIPS_CT);
    for (int i = 0; i < 6; i++) begin
      run_a(pts[i], keys[i], int'($urandom_range(0, 3)), (i < 5), pts[i+1]);
    end

    // flush at round 7 with a new block offered in the same cycle
    pt_f  = rand128();
    key_f = rand128();
    pt_g  = rand128();
    load_keys_a(key_f);
    in_data_a  = pt_f;
    in_valid_a = 1'b1;
    @(negedge clk);
    in_valid_a = 1'b0;
    repeat (6) @(negedge clk);
    chk("fl_round7", 128'(round_a), 128'(7));
    flush_a    = 1'b1;
    in_valid_a = 1'b1;
    in_data_a  = pt_g;
    @(negedge clk);
    flush_a = 1'b0;
    chk("fl_busy", 128'(busy_a), 128'(0));
    chk("fl_round", 128'(round_a), 128'(0));
    chk("fl_in_ready", 128'(in_ready_a), 128'(1));
    chk("fl_out_valid", 128'(out_valid_a), 128'(0));
    chk("fl_out_data_hold", out_data_a, last_ct);
    run_a(pt_g, key_f, 1, 1'b0, '0);

    // asynchronous reset at round 5
    load_keys_a(key_f);
    in_data_a  = pt_f;
    in_valid_a = 1'b1;
    @(negedge clk);
    in_valid_a = 1'b0;
    repeat (4) @(negedge clk);
    chk("rs_round5", 128'(round_a), 128'(5));
    #2 reset = 1'b0;
    #1;
    chk("rs_busy", 128'(busy_a), 128'(0));
    chk("rs_out_valid", 128'(out_valid_a), 128'(0));
    chk("rs_in_ready", 128'(in_ready_a), 128'(1));
    chk("rs_round", 128'(round_a), 128'(0));
    chk("rs_out_data", out_data_a, 128'(0));
    @(negedge clk);
    reset = 1'b1;
    run_a(rand128(), rand128(), 2, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
